// File: rtl/cmd_decoder_rpt.sv
// UART command decoder with decimal repeat prefix and mode-channel control.
// Single-byte commands from the RX FIFO become one-cycle control pulses.
// A decimal prefix repeats the S/M/H pulse commands; while a repeat burst
// runs, rx_ready is held low so the FIFO is backpressured. Mode channels
// toggle from a UART character or follow a synchronised board switch, and
// every change emits a one-cycle trigger.
module cmd_decoder_rpt #(
  parameter int unsigned               NUM_MODES  = 2,
  parameter logic [8*NUM_MODES-1:0]    MODE_CHARS = {8'h6D, 8'h6E},
  parameter int unsigned               MAX_REPEAT = 99,
  parameter int unsigned               PULSE_GAP  = 4,
  localparam int unsigned              CW         = $clog2(MAX_REPEAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [NUM_MODES-1:0] sw_mode,
  output logic                 o_runstop,
  output logic                 o_clear,
  output logic                 o_secup,
  output logic                 o_minup,
  output logic                 o_hourup,
  output logic [NUM_MODES-1:0] o_mode,
  output logic [NUM_MODES-1:0] o_mode_trig,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int unsigned GW = $clog2(PULSE_GAP + 1);
  // Wide enough for MAX_REPEAT*10 + 9 before saturation.
  localparam int unsigned AW = CW + 4;

  localparam logic [7:0] CH_RUN  = 8'h72;  // 'r'
  localparam logic [7:0] CH_CLR  = 8'h63;  // 'c'
  localparam logic [7:0] CH_SEC  = 8'h53;  // 'S'
  localparam logic [7:0] CH_MIN  = 8'h4D;  // 'M'
  localparam logic [7:0] CH_HOUR = 8'h48;  // 'H'
  localparam logic [7:0] CH_ESC  = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RPT_SEC  = 2'd0,
    RPT_MIN  = 2'd1,
    RPT_HOUR = 2'd2
  } rpt_e;

  state_e               state_q, state_d;
  rpt_e                 rpt_q, rpt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        rem_q, rem_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 busy_q, busy_d;
  logic                 runstop_q, runstop_d;
  logic                 clear_q, clear_d;
  logic                 secup_q, secup_d;
  logic                 minup_q, minup_d;
  logic                 hourup_q, hourup_d;
  logic                 err_q, err_d;
  logic [NUM_MODES-1:0] mode_q, mode_d;
  logic [NUM_MODES-1:0] trig_q, trig_d;
  logic [NUM_MODES-1:0] sync1_q, sync2_q, prev_q;

  logic                 accept;
  logic                 fire;
  rpt_e                 fire_kind;
  logic [CW-1:0]        n_rep;
  logic [AW-1:0]        acc_wide;
  logic [NUM_MODES-1:0] mode_match;
  logic [NUM_MODES-1:0] uart_hit;
  logic [NUM_MODES-1:0] sw_edge;

  // Switch edges are taken from the synchronised level against its previous value.
  assign sw_edge = sync2_q ^ prev_q;

  // Next-state, repeat-burst sequencing, command decode and mode-channel update.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned; that is what keeps this block free of latches.
    state_d    = state_q;
    rpt_d      = rpt_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
    runstop_d  = 1'b0;
    clear_d    = 1'b0;
    err_d      = 1'b0;
    fire       = 1'b0;
    fire_kind  = RPT_SEC;
    n_rep      = '0;
    acc_wide   = '0;
    mode_match = '0;
    uart_hit   = '0;
    mode_d     = mode_q;
    trig_d     = '0;
    accept     = rx_valid && rx_ready_q;

    // Lowest channel index wins when two toggle characters are equal.
    for (int k = NUM_MODES - 1; k >= 0; k--) begin
      if (rx_data == MODE_CHARS[8*k +: 8]) begin
        mode_match = NUM_MODES'(1) << k;
      end
    end

    if (state_q == ST_BURST) begin
      // After the last pulse one more cycle passes before rx_ready returns.
      if (rem_q == '0) begin
        state_d = ST_IDLE;
      end else if (gap_q != '0) begin
        gap_d = gap_q - GW'(1);
      end else begin
        fire      = 1'b1;
        fire_kind = rpt_q;
        rem_d     = rem_q - CW'(1);
        gap_d     = GW'(PULSE_GAP);
      end
    end else if (accept) begin
      // Any accepted byte other than a digit consumes the prefix.
      cnt_d   = '0;
      state_d = ST_IDLE;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
        acc_wide = AW'(cnt_q) * AW'(10) + AW'(rx_data[3:0]);
        cnt_d    = (acc_wide > AW'(MAX_REPEAT)) ? CW'(MAX_REPEAT) : acc_wide[CW-1:0];
        state_d  = ST_ACCUM;
      end else if (rx_data == CH_RUN) begin
        runstop_d = 1'b1;
      end else if (rx_data == CH_CLR) begin
        clear_d = 1'b1;
      end else if (rx_data == CH_SEC || rx_data == CH_MIN || rx_data == CH_HOUR) begin
        fire      = 1'b1;
        fire_kind = (rx_data == CH_SEC) ? RPT_SEC :
                    (rx_data == CH_MIN) ? RPT_MIN : RPT_HOUR;
        n_rep     = (cnt_q == '0) ? CW'(1) : cnt_q;
        if (n_rep > CW'(1)) begin
          state_d = ST_BURST;
          rpt_d   = fire_kind;
          rem_d   = n_rep - CW'(1);
          gap_d   = GW'(PULSE_GAP);
        end
      end else if (rx_data == CH_ESC) begin
        // Cancels a pending prefix silently.
      end else if (|mode_match) begin
        uart_hit = mode_match;
      end else begin
        err_d = 1'b1;
      end
    end

    // A switch edge overrides a same-cycle UART toggle on that channel.
    for (int k = 0; k < NUM_MODES; k++) begin
      if (sw_edge[k]) begin
        mode_d[k] = sync2_q[k];
        trig_d[k] = 1'b1;
      end else if (uart_hit[k]) begin
        mode_d[k] = ~mode_q[k];
        trig_d[k] = 1'b1;
      end
    end

    secup_d    = fire && (fire_kind == RPT_SEC);
    minup_d    = fire && (fire_kind == RPT_MIN);
    hourup_d   = fire && (fire_kind == RPT_HOUR);
    rx_ready_d = (state_d != ST_BURST);
    busy_d     = (state_d == ST_BURST);
  end

  // State, counters, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rpt_q      <= RPT_SEC;
      cnt_q      <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      runstop_q  <= 1'b0;
      clear_q    <= 1'b0;
      secup_q    <= 1'b0;
      minup_q    <= 1'b0;
      hourup_q   <= 1'b0;
      err_q      <= 1'b0;
      mode_q     <= '0;
      trig_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the sync1 -> sync2 -> prev chain shifts one stage per clock.
      state_q    <= state_d;
      rpt_q      <= rpt_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      runstop_q  <= runstop_d;
      clear_q    <= clear_d;
      secup_q    <= secup_d;
      minup_q    <= minup_d;
      hourup_q   <= hourup_d;
      err_q      <= err_d;
      mode_q     <= mode_d;
      trig_q     <= trig_d;
      sync1_q    <= sw_mode;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign o_busy      = busy_q;
  assign o_runstop   = runstop_q;
  assign o_clear     = clear_q;
  assign o_secup     = secup_q;
  assign o_minup     = minup_q;
  assign o_hourup    = hourup_q;
  assign o_err       = err_q;
  assign o_mode      = mode_q;
  assign o_mode_trig = trig_q;

endmodule

// File: tb/tb_cmd_decoder_rpt.sv
// Bench for cmd_decoder_rpt: a byte-level model pushes every expected output
// pulse (cycle, pulse vector, mode level) into a queue as stimulus is driven;
// a monitor pops and compares each pulse the DUT produces.
module tb_cmd_decoder_rpt;

  localparam int NM = 2;

  // Pulse vector bit positions: {err, runstop, clear, secup, minup, hourup, trig[1:0]}
  localparam logic [7:0] V_ERR  = 8'h80;
  localparam logic [7:0] V_RUN  = 8'h40;
  localparam logic [7:0] V_CLR  = 8'h20;
  localparam logic [7:0] V_SEC  = 8'h10;
  localparam logic [7:0] V_MIN  = 8'h08;
  localparam logic [7:0] V_HOUR = 8'h04;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
    logic [1:0] mode;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [NM-1:0] sw_mode;
  logic          o_runstop, o_clear, o_secup, o_minup, o_hourup;
  logic [NM-1:0] o_mode, o_mode_trig;
  logic          o_busy, o_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   cnt_m  = 0;
  logic [1:0] mode_m = 2'b00;
  exp_t sb[$];

  logic [7:0] mon_v;
  exp_t       mon_e;

  cmd_decoder_rpt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .sw_mode     (sw_mode),
    .o_runstop   (o_runstop),
    .o_clear     (o_clear),
    .o_secup     (o_secup),
    .o_minup     (o_minup),
    .o_hourup    (o_hourup),
    .o_mode      (o_mode),
    .o_mode_trig (o_mode_trig),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse must match the head entry; an entry whose
  // cycle has passed without a pulse is reported as missing.
  always @(negedge clk) begin
    mon_v = {o_err, o_runstop, o_clear, o_secup, o_minup, o_hourup, o_mode_trig};
    if (mon_v != 8'h00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got vec=%h mode=%b", cyc, mon_v, o_mode);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.vec !== mon_v || mon_e.mode !== o_mode) begin
          errors++;
          $display("FAIL pulse cyc=%0d got vec=%h mode=%b, want cyc=%0d vec=%h mode=%b",
                   cyc, mon_v, o_mode, mon_e.cyc, mon_e.vec, mon_e.mode);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      checks++;
      errors++;
      mon_e = sb.pop_front();
      $display("FAIL missing_pulse cyc=%0d got none, want vec=%h at cyc=%0d", cyc, mon_e.vec, mon_e.cyc);
    end
  end

  task automatic push_exp(input int c, input logic [7:0] v);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.mode = mode_m;
    sb.push_back(e);
  endtask

  // Reference behaviour of one accepted byte at edge acc.
  task automatic model_byte(input logic [7:0] b, input int acc);
    int n;
    logic [7:0] v;
    if (b >= 8'h30 && b <= 8'h39) begin
      cnt_m = cnt_m * 10 + int'(b - 8'h30);
      if (cnt_m > 99) cnt_m = 99;
    end else begin
      v = 8'h00;
      case (b)
        8'h72: push_exp(acc, V_RUN);
        8'h63: push_exp(acc, V_CLR);
        8'h53, 8'h4D, 8'h48: begin
          v = (b == 8'h53) ? V_SEC : (b == 8'h4D) ? V_MIN : V_HOUR;
          n = (cnt_m == 0) ? 1 : cnt_m;
          for (int i = 0; i < n; i++) push_exp(acc + 5 * i, v);
        end
        8'h1B: ;
        8'h6E: begin mode_m[0] = ~mode_m[0]; push_exp(acc, 8'h01); end
        8'h6D: begin mode_m[1] = ~mode_m[1]; push_exp(acc, 8'h02); end
        default: push_exp(acc, V_ERR);
      endcase
      cnt_m = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge where the byte's first pulse is visible.
  task automatic send_byte(input logic [7:0] b, output int acc);
    int waited = 0;
    while (rx_ready !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h got rx_ready=%b, want 1", b, rx_ready);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    acc      = cyc + 1;
    model_byte(b, acc);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    int acc;
    for (int i = 0; i < s.len(); i++) send_byte(s[i], acc);
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_runstop, o_clear, o_secup, o_minup, o_hourup, o_mode, o_mode_trig, o_busy, o_err, rx_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b, want all 0",
               {o_runstop, o_clear, o_secup, o_minup, o_hourup, o_mode, o_mode_trig, o_busy, o_err, rx_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rx_ready got %b, want 1", rx_ready);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (o_mode !== 2'b00) begin
      errors++;
      $display("FAIL reset_mode got %b, want 00", o_mode);
    end
  endtask

  task automatic test_single();
    int acc;
    send_byte("S", acc);
    checks++;
    if (o_busy !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got busy=%b ready=%b, want busy=0 ready=1", o_busy, rx_ready);
    end
    send_byte("c", acc);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_drain got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_burst();
    int acc;
    send_str("12");
    send_byte("M", acc);
    checks++;
    if (o_busy !== 1'b1 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL burst_start got busy=%b ready=%b, want busy=1 ready=0", o_busy, rx_ready);
    end
    while (cyc < acc + 55) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL burst_last got busy=%b ready=%b, want busy=1 ready=0", o_busy, rx_ready);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL burst_end got busy=%b ready=%b, want busy=0 ready=1", o_busy, rx_ready);
    end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL burst_drain got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_saturation();
    send_str("150H");
    wait_drain();
    send_str("7r");
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL saturation_drain got %0d pending, want 0", sb.size());
    end
  endtask

  // Raw switch change at negedge k is expected as a trig at cyc k+3; the
  // optional UART byte is accepted at that same edge.
  task automatic sw_aligned(input logic [1:0] sw_new, input logic use_n);
    int k;
    logic [1:0] tv;
    k  = cyc;
    tv = sw_new ^ sw_mode;
    sw_mode = sw_new;
    repeat (2) @(negedge clk);
    if (use_n) begin
      rx_data  = "n";
      rx_valid = 1'b1;
    end
    for (int c = 0; c < 2; c++) begin
      if (tv[c]) mode_m[c] = sw_new[c];
      else if (use_n && c == 0) begin
        mode_m[c] = ~mode_m[c];
        tv[c] = 1'b1;
      end
    end
    push_exp(k + 3, {6'b0, tv});
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_mode();
    send_str("nn");
    wait_drain();
    checks++;
    if (o_mode !== 2'b00) begin
      errors++;
      $display("FAIL mode_nn got %b, want 00", o_mode);
    end
    send_str("m");
    wait_drain();
    checks++;
    if (o_mode !== 2'b10) begin
      errors++;
      $display("FAIL mode_m got %b, want 10", o_mode);
    end
    send_str("mn");
    wait_drain();
    sw_aligned(2'b01, 1'b1);
    wait_drain();
    checks++;
    if (o_mode !== 2'b01) begin
      errors++;
      $display("FAIL mode_sw_wins got %b, want 01", o_mode);
    end
    sw_aligned(2'b11, 1'b1);
    wait_drain();
    checks++;
    if (o_mode !== 2'b10) begin
      errors++;
      $display("FAIL mode_two_ch got %b, want 10", o_mode);
    end
    sw_aligned(2'b00, 1'b0);
    wait_drain();
    checks++;
    if (o_mode !== mode_m || sb.size() != 0) begin
      errors++;
      $display("FAIL mode_sw_release got %b pending=%0d, want %b pending=0", o_mode, sb.size(), mode_m);
    end
  endtask

  task automatic test_err_esc();
    send_str("3x");
    send_str("S");
    send_str("5");
    send_byte(8'h1B, cnt_m);
    cnt_m = 0;
    send_str("S");
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL err_esc_drain got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int acc;
    send_str("9");
    send_byte("S", acc);
    while (cyc < acc + 7) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    cnt_m  = 0;
    mode_m = 2'b00;
    #1;
    checks++;
    if ({o_secup, o_busy, rx_ready, o_mode} !== '0) begin
      errors++;
      $display("FAIL rst_burst_outputs got %b, want all 0", {o_secup, o_busy, rx_ready, o_mode});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_burst_after got ready=%b busy=%b, want ready=1 busy=0", rx_ready, o_busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    sw_mode  = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_saturation();
    test_mode();
    test_err_esc();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
